ras_circ_stack: RTL

//  Parametrised return-address stack (RAS) for the frontend branch predictor.

---
 rtl/ras_circ_stack.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ras_circ_stack.sv
// Circular return-address stack: push/pop/replace-top, overwrite-oldest on overflow, optional checkpoint (RAS_CKPT_EN).
// Latency: one cycle from sampled push/pop/flush to visible top/count/flags; no backpressure, every request is accepted.
module ras_circ_stack #(
    parameter int VLEN  = 64,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [VLEN-1:0]   data_i,
`ifdef RAS_CKPT_EN
    input  logic              ckpt_save_i,
    input  logic              ckpt_restore_i,
`endif
    output logic [VLEN-1:0]   top_o,
    output logic              top_valid_o,
    output logic [PTR_W:0]    count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ras_circ_stack: DEPTH must be a power of two and >= 2");
    end
    if (PTR_W != $clog2(DEPTH)) begin : g_bad_ptr_w
        $error("ras_circ_stack: PTR_W must equal $clog2(DEPTH)");
    end

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [VLEN-1:0]  mem_q [DEPTH];
    logic [VLEN-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             restore_req;

`ifdef RAS_CKPT_EN
    logic [PTR_W-1:0] ckpt_tos_q, ckpt_tos_d;
    logic [PTR_W:0]   ckpt_cnt_q, ckpt_cnt_d;

    assign restore_req = ckpt_restore_i;

    always_comb begin
        ckpt_tos_d = ckpt_tos_q;
        ckpt_cnt_d = ckpt_cnt_q;
        if (flush_i) begin
            ckpt_tos_d = '0;
            ckpt_cnt_d = '0;
        end else if (ckpt_save_i && !ckpt_restore_i) begin
            ckpt_tos_d = tos_q;
            ckpt_cnt_d = count_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ckpt_tos_q <= '0;
            ckpt_cnt_q <= '0;
        end else begin
            ckpt_tos_q <= ckpt_tos_d;
            ckpt_cnt_q <= ckpt_cnt_d;
        end
    end
`else
    assign restore_req = 1'b0;
`endif

    always_comb begin
        mem_d       = mem_q;
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (flush_i) begin
            tos_d   = '0;
            count_d = '0;
        end else if (restore_req) begin
`ifdef RAS_CKPT_EN
            tos_d   = ckpt_tos_q;
            count_d = ckpt_cnt_q;
`endif
        end else if (push_i && pop_i && count_q != '0) begin
            mem_d[tos_q] = data_i;
        end else if (push_i) begin
            // Empty push+pop falls through here and acts as a plain push.
            tos_d        = tos_q + 1'b1;
            mem_d[tos_d] = data_i;
            if (count_q == FULL_CNT) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (pop_i) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                tos_d   = tos_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign top_o       = mem_q[tos_q];
    assign top_valid_o = (count_q != '0);
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule
